// File: rtl/tmu2_colsched_if.sv
// Descriptor-in / column-job-out bundle for the TMU2 column scheduler.
// The scheduler uses the slave view; the square fetch / interpolator side uses master.
interface tmu2_colsched_if #(
  parameter int CWIDTH = 11
);
  logic                    pipe_stb_i;
  logic                    pipe_ack_o;
  logic signed [11:0]      sq_x;
  logic signed [11:0]      sq_y;
  logic [CWIDTH-1:0]       sq_w;
  logic                    sq_last;
  logic                    pipe_stb_o;
  logic                    pipe_ack_i;
  logic signed [11:0]      drx;
  logic signed [11:0]      dry;
  logic                    col_first;
  logic                    col_last;
  logic                    ds_busy;

  modport slave (
    input  pipe_stb_i, sq_x, sq_y, sq_w, sq_last, pipe_ack_i, ds_busy,
    output pipe_ack_o, pipe_stb_o, drx, dry, col_first, col_last
  );

  modport master (
    output pipe_stb_i, sq_x, sq_y, sq_w, sq_last, pipe_ack_i, ds_busy,
    input  pipe_ack_o, pipe_stb_o, drx, dry, col_first, col_last
  );
endinterface

// File: rtl/tmu2_colsched.sv
// Column scheduler: turns one square descriptor into one job per destination
// column, then waits for the vertical interpolator to drain at frame end.
//
// state  | meaning
// IDLE   | ready for a descriptor (pipe_ack_o high)
// ISSUE  | column job valid, waiting for pipe_ack_i
// GUARD  | one cycle to let downstream ds_busy rise after the final job
// DRAIN  | waiting for ds_busy low, then pulse done
module tmu2_colsched #(
  parameter int CWIDTH = 11
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  tmu2_colsched_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GUARD = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic signed [11:0]  drx_q, drx_d;
  logic signed [11:0]  dry_q, dry_d;
  logic [CWIDTH-1:0]   rem_q, rem_d;
  logic [CWIDTH-1:0]   first_q, first_d;
  logic                last_sq_q, last_sq_d;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      drx_q     <= '0;
      dry_q     <= '0;
      rem_q     <= '0;
      first_q   <= '0;
      last_sq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drx_q     <= drx_d;
      dry_q     <= dry_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      last_sq_q <= last_sq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drx_d     = drx_q;
    dry_d     = dry_q;
    rem_d     = rem_q;
    first_d   = first_q;
    last_sq_d = last_sq_q;
    done      = 1'b0;

    // abort freezes the datapath and only redirects the state
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.pipe_stb_i) begin
            drx_d     = bus.sq_x;
            dry_d     = bus.sq_y;
            rem_d     = bus.sq_w - CWIDTH'(1);
            first_d   = bus.sq_w - CWIDTH'(1);
            last_sq_d = bus.sq_last;
            if (bus.sq_w != '0)   state_d = S_ISSUE;
            else if (bus.sq_last) state_d = S_GUARD;
          end
        end
        S_ISSUE: begin
          if (bus.pipe_ack_i) begin
            if (rem_q == '0) begin
              state_d = last_sq_q ? S_GUARD : S_IDLE;
            end else begin
              drx_d = drx_q + 12'sd1;
              rem_d = rem_q - CWIDTH'(1);
            end
          end
        end
        S_GUARD: state_d = S_DRAIN;
        S_DRAIN: begin
          if (!bus.ds_busy) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign bus.pipe_ack_o = (state_q == S_IDLE) && !abort;
  assign bus.pipe_stb_o = (state_q == S_ISSUE);
  assign bus.drx        = drx_q;
  assign bus.dry        = dry_q;
  assign bus.col_first  = (state_q == S_ISSUE) && (rem_q == first_q);
  assign bus.col_last   = (state_q == S_ISSUE) && (rem_q == '0);

endmodule

// File: tb/tb_tmu2_colsched.sv
// Directed bench for tmu2_colsched: expected column jobs are queued when a
// descriptor is sent and checked as each job is handshaked.
module tb_tmu2_colsched;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic abort;
  logic busy;
  logic done;

  tmu2_colsched_if #(.CWIDTH(11)) bus ();

  tmu2_colsched #(.CWIDTH(11)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .bus       (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic               f;
    logic               l;
  } job_t;

  job_t exp_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   done_cnt  = 0;
  int   stb_cnt   = 0;
  logic stall_q   = 1'b0;
  logic signed [11:0] held_drx;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic signed [11:0] x, input logic signed [11:0] y,
                      input int w, input logic last);
    int n = 0;
    job_t j;
    while (bus.pipe_ack_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ack_o_ready", bus.pipe_ack_o, 1);
    bus.pipe_stb_i = 1'b1;
    bus.sq_x       = x;
    bus.sq_y       = y;
    bus.sq_w       = 11'(w);
    bus.sq_last    = last;
    for (int i = 0; i < w; i++) begin
      j.x = x + 12'(i);
      j.y = y;
      j.f = (i == 0);
      j.l = (i == w - 1);
      exp_q.push_back(j);
    end
    tick();
    bus.pipe_stb_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge sys_clk);
      #1;
    end
    @(posedge sys_clk);
    #1;
  endtask

  // Job checker: every handshake must match the head of the expected queue
  always @(negedge sys_clk) begin
    job_t j;
    if (sys_rst_n === 1'b1) begin
      if (done === 1'b1) done_cnt++;
      if (bus.pipe_stb_o === 1'b1) begin
        stb_cnt++;
        if (stall_q) chk("hold_drx", bus.drx, held_drx);
        if (bus.pipe_ack_i === 1'b1) begin
          stall_q = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_job", 1, 0);
          end else begin
            j = exp_q.pop_front();
            chk("job_drx", bus.drx, j.x);
            chk("job_dry", bus.dry, j.y);
            chk("job_first", bus.col_first, j.f);
            chk("job_last", bus.col_last, j.l);
          end
        end else begin
          stall_q  = 1'b1;
          held_drx = bus.drx;
        end
      end else begin
        stall_q = 1'b0;
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    int lat;
    int d0;
    int s0;
    int k;

    sys_rst_n      = 1'b0;
    abort          = 1'b0;
    bus.pipe_stb_i = 1'b0;
    bus.sq_x       = '0;
    bus.sq_y       = '0;
    bus.sq_w       = '0;
    bus.sq_last    = 1'b0;
    bus.pipe_ack_i = 1'b0;
    bus.ds_busy    = 1'b0;

    repeat (3) tick();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_o", bus.pipe_ack_o, 1);
    chk("rst_stb_o", bus.pipe_stb_o, 0);
    chk("rst_drx", bus.drx, 0);
    chk("rst_dry", bus.dry, 0);
    chk("rst_col_first", bus.col_first, 0);
    chk("rst_col_last", bus.col_last, 0);
    tick();

    // single square, continuous ack
    bus.pipe_ack_i = 1'b1;
    send(12'sd10, 12'sd5, 4, 1'b1);
    wait_done(20, lat);
    chk("single_done_lat", lat, 5);
    @(negedge sys_clk);
    chk("single_done_pulse", done, 0);
    chk("single_idle", busy, 0);
    chk("single_queue", exp_q.size(), 0);
    tick();

    // backpressure ack pattern 1,0,0 then downstream busy for 5 cycles
    bus.pipe_ack_i = 1'b0;
    send(12'sd10, 12'sd5, 4, 1'b1);
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      bus.pipe_ack_i = (k % 3 == 0);
      tick();
      k++;
    end
    chk("bp_queue", exp_q.size(), 0);
    bus.pipe_ack_i = 1'b0;
    bus.ds_busy    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("bp_no_done", done, 0);
      chk("bp_busy", busy, 1);
      tick();
    end
    bus.ds_busy = 1'b0;
    wait_done(5, lat);
    chk("bp_done_lat", lat, 0);

    // 12-bit wrap of drx
    bus.pipe_ack_i = 1'b1;
    d0 = done_cnt;
    send(12'sd2047, 12'sd0, 2, 1'b0);
    repeat (3) tick();
    @(negedge sys_clk);
    chk("wrap_queue", exp_q.size(), 0);
    chk("wrap_idle", busy, 0);
    chk("wrap_no_done", done_cnt, d0);
    tick();

    // zero width, not last
    s0 = stb_cnt;
    send(12'sd100, 12'sd7, 0, 1'b0);
    @(negedge sys_clk);
    chk("w0_busy", busy, 0);
    chk("w0_ack_o", bus.pipe_ack_o, 1);
    chk("w0_drx_latched", bus.drx, 100);
    chk("w0_no_stb", stb_cnt, s0);
    tick();

    // zero width, last square of frame
    send(-12'sd5, 12'sd3, 0, 1'b1);
    wait_done(10, lat);
    chk("w0l_done_lat", lat, 1);
    chk("w0l_no_stb", stb_cnt, s0);

    // abort after 3 acks
    d0 = done_cnt;
    send(12'sd10, 12'sd5, 8, 1'b1);
    repeat (3) tick();
    bus.pipe_ack_i = 1'b0;
    abort          = 1'b1;
    @(negedge sys_clk);
    chk("abort_stb_still", bus.pipe_stb_o, 1);
    chk("abort_no_done", done, 0);
    tick();
    abort = 1'b0;
    @(negedge sys_clk);
    chk("abort_idle", busy, 0);
    chk("abort_stb_o", bus.pipe_stb_o, 0);
    chk("abort_drx_kept", bus.drx, 13);
    exp_q.delete();
    tick();

    // abort in IDLE blocks the descriptor
    bus.pipe_stb_i = 1'b1;
    bus.sq_x       = 12'sd99;
    bus.sq_w       = 11'd3;
    bus.sq_last    = 1'b1;
    abort          = 1'b1;
    @(negedge sys_clk);
    chk("abort_gates_ack_o", bus.pipe_ack_o, 0);
    tick();
    bus.pipe_stb_i = 1'b0;
    abort          = 1'b0;
    @(negedge sys_clk);
    chk("abort_not_latched", busy, 0);
    chk("abort_drx_unchanged", bus.drx, 13);
    repeat (5) tick();
    chk("abort_done_cnt", done_cnt, d0);

    // reset mid-square
    bus.pipe_ack_i = 1'b1;
    send(12'sd20, 12'sd9, 8, 1'b1);
    repeat (3) tick();
    bus.pipe_ack_i = 1'b0;
    sys_rst_n      = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    exp_q.delete();
    @(negedge sys_clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_ack_o", bus.pipe_ack_o, 1);
    chk("mrst_stb_o", bus.pipe_stb_o, 0);
    chk("mrst_drx", bus.drx, 0);
    chk("mrst_dry", bus.dry, 0);
    chk("mrst_col_first", bus.col_first, 0);
    repeat (5) tick();
    chk("mrst_done_cnt", done_cnt, d0);
    chk("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmu2_colsched.md
# tmu2_colsched

Column scheduler for the TMU2 vertical interpolation stage. It accepts one destination-square descriptor at a time and issues one column job per destination column to the vertical interpolator: start X/Y and first/last flags, with a strobe/ack handshake. At frame end it waits for the interpolator to drain, then signals completion. It sits between the mesh/square fetch logic and the vertical interpolator.

## Interface
Parameters:
- CWIDTH, 11, width of the column counter and of `sq_w`. Must be ≥1.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge
- sys_rst_n  in  1  reset, synchronous, active-low
- abort  in  1  synchronous abort; returns to IDLE without `done`
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a frame has fully drained
- pipe_stb_i  in  1  square descriptor valid
- pipe_ack_o  out  1  descriptor accepted (high in IDLE only)
- sq_x  in  12 signed  destination X of the square's first column
- sq_y  in  12 signed  destination Y of the square's top row
- sq_w  in  CWIDTH  number of columns in the square; 0 is legal
- sq_last  in  1  this is the last square of the frame
- pipe_stb_o  out  1  column job valid (high in ISSUE only)
- pipe_ack_i  in  1  downstream accepts the column job
- drx  out  12 signed  column X, registered
- dry  out  12 signed  column Y, registered
- col_first  out  1  current job is column 0 of its square
- col_last  out  1  current job is the final column of its square
- ds_busy  in  1  downstream interpolator busy

## Operation
- States: IDLE, ISSUE, GUARD, DRAIN. The state register resets to IDLE.
- IDLE: `pipe_ack_o`=1. On `pipe_stb_i`:
  - latch `drx`←`sq_x`, `dry`←`sq_y`, `remaining`←`sq_w`−1, `last_sq`←`sq_last`.
  - If `sq_w`≠0, go to ISSUE.
  - If `sq_w`=0 and `sq_last`=1, go to GUARD.
  - If `sq_w`=0 and `sq_last`=0, stay in IDLE. The descriptor is consumed and no job is issued.
- ISSUE: `pipe_stb_o`=1. Outputs are held stable while `pipe_ack_i`=0. On `pipe_ack_i`:
  - If `remaining`=0, go to GUARD when `last_sq`=1, otherwise go to IDLE.
  - Else `drx`←`drx`+1 (12-bit wrap, `dry` unchanged) and `remaining`←`remaining`−1.
- `col_first` = (ISSUE and `remaining` = latched `sq_w`−1). `col_last` = (ISSUE and `remaining`=0). Both are 0 outside ISSUE.
- GUARD: one cycle, `ds_busy` ignored, always goes to DRAIN. This covers the downstream one-cycle busy latency.
- DRAIN: when `ds_busy`=0, pulse `done`=1 for one cycle and go to IDLE.
- `abort` (priority below reset, above all other events): next state IDLE, `done`=0, datapath registers unchanged. A descriptor strobed in the same cycle is not latched, and `pipe_ack_o` is forced to 0 that cycle.
- Reset during any state: next cycle is IDLE. Any in-flight descriptor and any pending `done` are discarded.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `pipe_stb_o`=0, `pipe_ack_o`=1 (IDLE), `col_first`=0, `col_last`=0.
  - `drx`=0, `dry`=0, `remaining`=0, `last_sq`=0.
- Descriptor accepted at edge N. The first job is valid in cycle N+1 (`pipe_stb_o`=1, `drx`=`sq_x`).
- Throughput is one column per cycle while `pipe_ack_i` is held high. A square of width W with continuous ack occupies W ISSUE cycles.
- Back-to-back squares: one IDLE cycle between the last column ack and the next `pipe_stb_o`.
- `done` fires, at the earliest, 2 cycles after the final ack (GUARD, then DRAIN with `ds_busy`=0). It is delayed while `ds_busy`=1.
- `pipe_ack_o` and `pipe_stb_o` are decoded from the state only, with no combinational path from the `_i` strobes, except that `abort` gates `pipe_ack_o`.
- `busy` is high from the cycle after acceptance until the cycle after `done` (exclusive).

## Test plan
- Reset: hold `sys_rst_n`=0 for 3 cycles, then release → `busy`=0, `pipe_ack_o`=1, `pipe_stb_o`=0, `drx`=`dry`=0.
- Single square: `sq_x`=10, `sq_y`=5, `sq_w`=4, `sq_last`=1, `pipe_ack_i`=1 → jobs `drx`=10,11,12,13 in consecutive cycles with `dry`=5.
  - `col_first` on 10 only; `col_last` on 13 only.
  - `done` 2 cycles after the last ack when `ds_busy`=0.
- Backpressure and drain: same square, `pipe_ack_i` toggling 1,0,0,1,… → each `drx` is held until acked.
  - Hold `ds_busy`=1 for 5 cycles after the last ack → `done` appears only after `ds_busy` falls.
- Wrap and zero width:
  - `sq_x`=2047, `sq_w`=2 → `drx`=2047 then −2048.
  - `sq_w`=0, `sq_last`=0 → no `pipe_stb_o`, back in IDLE next cycle.
  - `sq_w`=0, `sq_last`=1 → `done` with no jobs issued.
- Abort/reset mid-square: `sq_w`=8, assert `abort` after 3 acks → IDLE next cycle, no `done`.
  - Repeat with `sys_rst_n`=0 instead of `abort` → all reset values.
